// File: rtl/morse_rx_fsm.sv
// Morse line receiver: measures mark/space run lengths, classifies
// dots and dashes and assembles up to five symbols per character.
module morse_rx_fsm #(
    parameter int unsigned UNIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       led_in,
    output logic       sym_valid,
    output logic       symbol,
    output logic       char_valid,
    output logic [4:0] char_code,
    output logic [2:0] char_len,
    output logic       err
);

    localparam logic [15:0] DASH_MIN = 16'(2 * UNIT);
    localparam logic [15:0] MARK_ERR = 16'(4 * UNIT + 1);
    localparam logic [15:0] GAP_END  = 16'(3 * UNIT);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        LOCKOUT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [4:0]  buf_q, buf_d;
    logic [2:0]  len_q, len_d;
    logic        is_dash;

    logic       sym_valid_q, sym_valid_d;
    logic       symbol_q, symbol_d;
    logic       char_valid_q, char_valid_d;
    logic [4:0] code_q, code_d;
    logic [2:0] clen_q, clen_d;
    logic       err_q, err_d;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign is_dash = (cnt_q >= DASH_MIN);

    assign sym_valid  = sym_valid_q;
    assign symbol     = symbol_q;
    assign char_valid = char_valid_q;
    assign char_code  = code_q;
    assign char_len   = clen_q;
    assign err        = err_q;

    // Next-state, run counter, symbol buffer and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        len_d        = len_q;
        sym_valid_d  = 1'b0;
        symbol_d     = symbol_q;
        char_valid_d = 1'b0;
        code_d       = code_q;
        clen_d       = clen_q;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (led_in) begin
                    state_d = MARK;
                    cnt_d   = 16'd1;
                end
            end
            MARK: begin
                if (led_in) begin
                    if (cnt_inc == MARK_ERR) begin
                        err_d   = 1'b1;
                        buf_d   = 5'd0;
                        len_d   = 3'd0;
                        cnt_d   = 16'd0;
                        state_d = LOCKOUT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    sym_valid_d   = 1'b1;
                    symbol_d      = is_dash;
                    buf_d[len_q]  = is_dash;
                    len_d         = len_q + 3'd1;
                    cnt_d         = 16'd1;
                    state_d       = SPACE;
                end
            end
            SPACE: begin
                if (led_in) begin
                    if (len_q == 3'd5) begin
                        err_d   = 1'b1;
                        buf_d   = 5'd0;
                        len_d   = 3'd0;
                        cnt_d   = 16'd0;
                        state_d = LOCKOUT;
                    end else begin
                        cnt_d   = 16'd1;
                        state_d = MARK;
                    end
                end else if (cnt_inc == GAP_END) begin
                    char_valid_d = 1'b1;
                    code_d       = buf_q;
                    clen_d       = len_q;
                    buf_d        = 5'd0;
                    len_d        = 3'd0;
                    cnt_d        = 16'd0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LOCKOUT: begin
                if (led_in) begin
                    cnt_d = 16'd0;
                end else if (cnt_inc == GAP_END) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                buf_d   = 5'd0;
                len_d   = 3'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            buf_q        <= 5'd0;
            len_q        <= 3'd0;
            sym_valid_q  <= 1'b0;
            symbol_q     <= 1'b0;
            char_valid_q <= 1'b0;
            code_q       <= 5'd0;
            clen_q       <= 3'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            sym_valid_q  <= sym_valid_d;
            symbol_q     <= symbol_d;
            char_valid_q <= char_valid_d;
            code_q       <= code_d;
            clen_q       <= clen_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_rx_fsm.sv
// Scoreboard bench for morse_rx_fsm at UNIT=1 and UNIT=4.
// Expected pulses are queued with their cycle as stimulus is driven.
module tb_morse_rx_fsm;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic led_in = 1'b0;
    logic sel = 1'b0;

    logic       sv1, sy1, cv1, er1;
    logic [4:0] cc1;
    logic [2:0] cl1;
    logic       sv4, sy4, cv4, er4;
    logic [4:0] cc4;
    logic [2:0] cl4;

    logic       m_sv, m_sy, m_cv, m_er;
    logic [4:0] m_cc;
    logic [2:0] m_cl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t q[$];

    morse_rx_fsm #(.UNIT(1)) u1 (
        .clock(clock), .reset(reset), .led_in(led_in),
        .sym_valid(sv1), .symbol(sy1), .char_valid(cv1),
        .char_code(cc1), .char_len(cl1), .err(er1)
    );

    morse_rx_fsm #(.UNIT(4)) u4 (
        .clock(clock), .reset(reset), .led_in(led_in),
        .sym_valid(sv4), .symbol(sy4), .char_valid(cv4),
        .char_code(cc4), .char_len(cl4), .err(er4)
    );

    assign m_sv = sel ? sv4 : sv1;
    assign m_sy = sel ? sy4 : sy1;
    assign m_cv = sel ? cv4 : cv1;
    assign m_er = sel ? er4 : er1;
    assign m_cc = sel ? cc4 : cc1;
    assign m_cl = sel ? cl4 : cl1;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            led_in = v;
            last = cyc;
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.at = last + 1;
        q.push_back(e);
    endtask

    task automatic exp_sym(input logic s);
        expect_ev(1, {7'd0, s});
    endtask

    task automatic exp_char(input logic [2:0] len, input logic [4:0] code);
        expect_ev(2, {len, code});
    endtask

    task automatic exp_err();
        expect_ev(3, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        led_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Pop and compare one expected event for every output pulse
    always @(negedge clock) begin
        if (!reset && (m_sv || m_cv || m_er)) begin
            int         kind;
            logic [7:0] data;
            ev_t        e;
            kind = m_sv ? 1 : (m_cv ? 2 : 3);
            data = m_sv ? {7'd0, m_sy} : (m_cv ? {m_cl, m_cc} : 8'd0);
            chk("excl", 32'(m_sv) + 32'(m_cv) + 32'(m_er), 1);
            chk("pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("kind", kind, e.kind);
                chk("data", 32'(data), 32'(e.data));
                chk("cycle", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_sv", 32'(sv1), 0);
        chk("rst_sy", 32'(sy1), 0);
        chk("rst_cv", 32'(cv1), 0);
        chk("rst_cc", 32'(cc1), 0);
        chk("rst_cl", 32'(cl1), 0);
        chk("rst_er", 32'(er1), 0);
        reset = 1'b0;
        drive(0, 2);

        // E
        drive(1, 1);
        drive(0, 1); exp_sym(0);
        drive(0, 2); exp_char(3'd1, 5'b00000);
        drive(0, 3);
        chk("hold_len", 32'(cl1), 1);

        // A
        drive(1, 1);
        drive(0, 1); exp_sym(0);
        drive(1, 3);
        drive(0, 1); exp_sym(1);
        drive(0, 2); exp_char(3'd2, 5'b00010);
        drive(0, 3);
        chk("hold_code", 32'(cc1), 32'h2);
        chk("hold_sym", 32'(sy1), 1);

        // Mark too long, lockout, then E
        drive(1, 5); exp_err();
        drive(0, 3);
        drive(1, 1);
        drive(0, 1); exp_sym(0);
        drive(0, 2); exp_char(3'd1, 5'b00000);
        drive(0, 3);

        // Overflow on the sixth mark
        for (int k = 0; k < 5; k++) begin
            drive(1, 1);
            drive(0, 1); exp_sym(0);
        end
        drive(1, 1); exp_err();
        drive(0, 6);

        // Async reset mid-character, then T
        drive(1, 1);
        drive(0, 1); exp_sym(0);
        drive(1, 3);
        drive(0, 1);
        @(posedge clock);
        #2;
        chk("pre_rst_sv", 32'(sv1), 1);
        reset = 1'b1;
        #1;
        chk("ar_sv", 32'(sv1), 0);
        chk("ar_sy", 32'(sy1), 0);
        chk("ar_cc", 32'(cc1), 0);
        chk("ar_cl", 32'(cl1), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drive(0, 5);
        drive(1, 3);
        drive(0, 1); exp_sym(1);
        drive(0, 2); exp_char(3'd1, 5'b00001);
        drive(0, 3);
        chk("u1_drained", q.size(), 0);

        // UNIT=4 boundaries
        sel = 1'b1;
        do_reset();
        drive(0, 2);
        drive(1, 7);
        drive(0, 1); exp_sym(0);
        drive(0, 11); exp_char(3'd1, 5'b00000);
        drive(1, 8);
        drive(0, 1); exp_sym(1);
        drive(0, 11); exp_char(3'd1, 5'b00001);
        drive(1, 16);
        drive(0, 1); exp_sym(1);
        drive(0, 11); exp_char(3'd1, 5'b00001);
        drive(1, 17); exp_err();
        drive(0, 12);
        drive(0, 20);
        chk("u4_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
